// File: rtl/taillight_mode_if.sv
// Switch inputs and mode/step outputs between the tail-light front end and its neighbours.
interface taillight_mode_if;
  logic left_in;
  logic right_in;
  logic haz_in;
  logic tick;
  logic left;
  logic right;
  logic haz;
  logic mode_chg;
  logic stuck;

  modport master (
    output left_in, right_in, haz_in,
    input  tick, left, right, haz, mode_chg, stuck
  );

  modport slave (
    input  left_in, right_in, haz_in,
    output tick, left, right, haz, mode_chg, stuck
  );
endinterface

// File: rtl/taillight_mode_ctrl.sv
// Thunderbird tail-light front end: switch sync/debounce, step tick and per-tick mode arbitration.
//   state      | meaning
//   MODE_OFF   | no lamps requested (also forced by turn timeout)
//   MODE_LEFT  | left-turn sequence
//   MODE_RIGHT | right-turn sequence
//   MODE_HAZ   | hazard, overrides lockout
module taillight_mode_ctrl #(
  parameter int unsigned TICK_DIV    = 25_000_000,
  parameter int unsigned DEB_CYCLES  = 500_000,
  parameter int unsigned STUCK_TICKS = 60
) (
  input  logic             clk_i,
  input  logic             rst_i,
  taillight_mode_if.slave  tl
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(STUCK_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_TICKS - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_HAZ   = 2'd3
  } mode_e;

  // bit order everywhere: [0]=left, [1]=right, [2]=hazard
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q;
  logic [DW-1:0] deb_cnt_q [3];

  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  mode_e         mode_q, mode_d, req;
  logic [SW-1:0] stuck_cnt_q, stuck_cnt_d;
  logic          lock_q, lock_d;
  logic          chg_q, chg_d;
  logic          left_q, right_q, haz_q;

  assign raw = {tl.haz_in, tl.right_in, tl.left_in};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (deb_cnt_q[i] == DEB_LAST) begin
            deb_q[i]     <= sync2_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i)     tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  always_comb begin
    req         = MODE_OFF;
    mode_d      = mode_q;
    lock_d      = lock_q;
    stuck_cnt_d = stuck_cnt_q;
    chg_d       = 1'b0;

    if (deb_q[2])                             req = MODE_HAZ;
    else if (deb_q[0] && !deb_q[1] && !lock_q) req = MODE_LEFT;
    else if (deb_q[1] && !deb_q[0] && !lock_q) req = MODE_RIGHT;

    if (tick) begin
      mode_d      = req;
      stuck_cnt_d = '0;
      // a turn mode held unchanged for STUCK_TICKS ticks is forced off and locked out
      if ((req == MODE_LEFT || req == MODE_RIGHT) && req == mode_q) begin
        if (stuck_cnt_q == STUCK_LAST) begin
          mode_d = MODE_OFF;
          lock_d = 1'b1;
        end else begin
          stuck_cnt_d = stuck_cnt_q + 1'b1;
        end
      end
      if (!deb_q[0] && !deb_q[1]) lock_d = 1'b0;
      chg_d = (mode_d != mode_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q      <= MODE_OFF;
      stuck_cnt_q <= '0;
      lock_q      <= 1'b0;
      chg_q       <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      haz_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      stuck_cnt_q <= stuck_cnt_d;
      lock_q      <= lock_d;
      chg_q       <= chg_d;
      left_q      <= (mode_d == MODE_LEFT);
      right_q     <= (mode_d == MODE_RIGHT);
      haz_q       <= (mode_d == MODE_HAZ);
    end
  end

  assign tl.tick     = tick;
  assign tl.left     = left_q;
  assign tl.right    = right_q;
  assign tl.haz      = haz_q;
  assign tl.mode_chg = chg_q;
  assign tl.stuck    = lock_q;

endmodule

// File: tb/tb_taillight_mode_ctrl.sv
// Self-checking bench for taillight_mode_ctrl: cycle model plus directed literal checks and random switching.
module tb_taillight_mode_ctrl;
  localparam int TD  = 8;
  localparam int DEB = 3;
  localparam int ST  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  taillight_mode_if tl();

  taillight_mode_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DEB), .STUCK_TICKS(ST)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .tl    (tl.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // behavioural model: mode as 0=off 1=left 2=right 3=hazard
  int       k;
  bit [2:0] m_s1, m_s2, m_db, m_raw;
  int       m_run [3];
  int       m_mode, m_req, m_new, m_streak;
  bit       m_lock, m_chg;

  always @(posedge clk) begin
    m_raw = {tl.haz_in, tl.right_in, tl.left_in};
    if (rst) begin
      k = 0; m_s1 = 0; m_s2 = 0; m_db = 0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      m_mode = 0; m_streak = 0; m_lock = 0; m_chg = 0;
    end else begin
      if (k % TD == TD - 1) begin
        if (m_db[2])                              m_req = 3;
        else if (m_db[0] && !m_db[1] && !m_lock)  m_req = 1;
        else if (m_db[1] && !m_db[0] && !m_lock)  m_req = 2;
        else                                      m_req = 0;
        m_new = m_req;
        if ((m_req == 1 || m_req == 2) && m_req == m_mode) begin
          m_streak++;
          if (m_streak == ST) begin
            m_new = 0; m_lock = 1; m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
        if (!m_db[0] && !m_db[1]) m_lock = 0;
        m_chg  = (m_new != m_mode);
        m_mode = m_new;
      end else begin
        m_chg = 0;
      end
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_db[i] = m_s2[i]; m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = m_raw;
      k++;
    end
  end

  logic [5:0] exp_v, act_v;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = {(k % TD == TD - 1), m_mode == 1, m_mode == 2, m_mode == 3, m_chg, m_lock};
      act_v = {tl.tick, tl.left, tl.right, tl.haz, tl.mode_chg, tl.stuck};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL per_cycle t=%0t {tick,l,r,h,chg,stuck} got=%b exp=%b", $time, act_v, exp_v);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic set_in(input bit l, input bit r, input bit h);
    tl.left_in = l; tl.right_in = r; tl.haz_in = h;
  endtask

  // leaves the bench at the negedge opening clock 1 after release
  task automatic do_reset(input int n);
    rst = 1'b1;
    set_in(0, 0, 0);
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    set_in(0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;

    // idle: ticks at clocks 8,16,24, nothing else
    do_reset(2);
    for (int p = 1; p <= 24; p++) begin
      check("idle_tick", tl.tick, (p % 8 == 0));
      check("idle_outs", {tl.left, tl.right, tl.haz, tl.mode_chg, tl.stuck}, 0);
      @(negedge clk);
    end

    // left held from clock 1: visible at clock 9 with a one-clock Mode_Chg
    do_reset(2);
    set_in(1, 0, 0);
    for (int p = 1; p <= 12; p++) begin
      check("left_rise", tl.left, (p >= 9));
      check("left_chg", tl.mode_chg, (p == 9));
      check("left_others", {tl.right, tl.haz}, 0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset", {tl.tick, tl.left, tl.right, tl.haz, tl.mode_chg, tl.stuck}, 0);

    // two-clock glitch is rejected
    do_reset(2);
    set_in(1, 0, 0);
    repeat (2) @(negedge clk);
    set_in(0, 0, 0);
    repeat (30) @(negedge clk);
    check("glitch_left", tl.left, 0);

    // hazard overrides left mid-period, then left returns
    set_in(1, 0, 0);
    repeat (20) @(negedge clk);
    set_in(1, 0, 1);
    repeat (25) @(negedge clk);
    check("haz_over_left", {tl.left, tl.haz}, 1);
    set_in(1, 0, 0);
    repeat (25) @(negedge clk);
    check("left_after_haz", {tl.left, tl.haz}, 2);

    // both turn switches give off, dropping right restores left
    set_in(1, 1, 0);
    repeat (25) @(negedge clk);
    check("both_off", {tl.left, tl.right, tl.haz}, 0);
    set_in(1, 0, 0);
    repeat (25) @(negedge clk);
    check("left_again", tl.left, 1);

    // right held: on for clocks 9..40, then timeout lockout
    do_reset(2);
    set_in(0, 1, 0);
    for (int p = 1; p <= 44; p++) begin
      check("stuck_right", tl.right, (p >= 9 && p <= 40));
      check("stuck_flag", tl.stuck, (p >= 41));
      @(negedge clk);
    end
    set_in(0, 1, 1);
    repeat (20) @(negedge clk);
    check("haz_in_lock", {tl.haz, tl.stuck}, 3);
    set_in(0, 0, 0);
    repeat (20) @(negedge clk);
    check("lock_cleared", tl.stuck, 0);

    // random switching with occasional short glitches and resets
    for (int s = 0; s < 160; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset($urandom_range(1, 2));
      end
      set_in($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
